vblank_job_scheduler: RTL and testbench
=======================================

Name: vblank_job_scheduler

Overview:
- Sequences the per-frame game-state update jobs (paddle input, paddle move, ball move/collision, score) inside vertical blanking.
- Watches the VGA timing generator's sx/sy counters and opens a scheduling window at the first blanking line.
- Issues enabled jobs one at a time over a start/done handshake, lowest index first.
- Enforces a deadline line and per-job timeout, and reports overruns so game state never changes during active video.

Parameters:
N_JOBS, 4, number of job requesters (1..8)
VBLANK_LINE, 480, sy value that opens the window (first non-active line)
DEADLINE_LINE, 520, sy value by which all jobs must be complete
TIMEOUT, 4096, max clk cycles a job may take from its start pulse to its done
FCW, 16, frame_count width

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
sx  in  10  horizontal pixel counter from timing generator
sy  in  10  vertical line counter from timing generator
job_mask  in  N_JOBS  jobs to run this frame; sampled at window open
job_done  in  N_JOBS  completion strobes from jobs
clr_status  in  1  clears overrun and job_timeout
job_start  out  N_JOBS  one-hot, one-cycle start pulse
busy  out  1  high while a window is being processed
frame_tick  out  1  one-cycle pulse at window open
frame_done  out  1  one-cycle pulse when all masked jobs finish before deadline
overrun  out  1  sticky: deadline reached with jobs outstanding
overrun_count  out  8  saturating count of overruns
job_timeout  out  N_JOBS  sticky per-job timeout flags
frame_count  out  FCW  windows opened since reset, wraps

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, timeout counter 0. A reset mid-window aborts the window and emits no pulses.
- Events are decoded combinationally and acted on at the next edge:
  - open_evt = (sy==VBLANK_LINE && sx==0)
  - dl_evt = (sy==DEADLINE_LINE && sx==0)
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - On open_evt at cycle T: latch job_mask into pending; frame_tick=1 at T+1; frame_count++ at T+1; busy=1 from T+1; go ISSUE.
- ISSUE (one cycle):
  - pending==0 -> FINISH.
  - Otherwise pick k = lowest set bit of pending, clear it, drive job_start[k]=1 for exactly that cycle, clear the timeout counter, go WAIT.
  - First job_start therefore appears at T+2.
- WAIT:
  - job_done[k] is accepted from the cycle job_start[k] is high onward. Acceptance -> ISSUE, so the next job_start appears 2 cycles after the accepted done.
  - job_done bits other than k are ignored.
  - Counter reaching TIMEOUT with no done -> set job_timeout[k], go ISSUE (job abandoned).
- FINISH (one cycle): frame_done=1, busy=0 next cycle, go IDLE.
- dl_evt while in ISSUE or WAIT:
  - Abort: pending cleared, state IDLE, busy=0, no frame_done.
  - Set overrun; overrun_count++ (saturates at 255).
  - dl_evt wins over a same-cycle job_done or timeout; the job counts as incomplete.
- open_evt while not IDLE (mis-set parameters): treated as an overrun. Abort as above, then the window is reopened in the same transition (frame_tick, count, new mask).
- dl_evt in IDLE or FINISH: no effect.
- clr_status clears overrun and job_timeout. Same-cycle set has priority over clear. overrun_count is cleared only by reset.
- Only one job_start bit is ever high; no job_start is issued outside ISSUE.
- sx/sy are assumed glitch-free registered outputs; each event is one cycle wide because sx advances every clk.

Test Plan:
- Normal window: mask=4'b1011; each done returned 5 cycles after its start -> job_start 0,1,3 in order; next start 2 cycles after each done; frame_done once; frame_count=1; overrun=0.
- Empty mask: mask=0 -> frame_tick at T+1; frame_done at T+3 (ISSUE then FINISH); no job_start.
- Timeout: job 1 never completes, TIMEOUT=16 -> job_timeout=4'b0010 at start+16; job 3 still issued; frame_done pulses; clr_status clears the flag.
- Deadline overrun: job 0 holds done low until after sy=DEADLINE_LINE, with TIMEOUT large and done arriving the same cycle as the deadline action -> overrun=1, overrun_count=1, no frame_done, busy=0; a late done is ignored.
- Reset mid-WAIT: reset asserted during job 2 -> all outputs 0 next cycle; next open_evt restarts at job 0 with frame_count=1.
- Saturation and clear race: 256 forced overruns -> overrun_count=255; clr_status coincident with a new overrun -> overrun stays 1.

Source files
------------

// File: rtl/vblank_job_scheduler.sv
// vblank_job_scheduler: runs the per-frame game-state jobs one at a time inside vertical blanking.
// Latency: frame_tick 1 cycle after the window-open line; first job_start 2 cycles after it; next start 2 cycles after an accepted done.
// Backpressure: a job holds the scheduler until it strobes done, times out, or the deadline line aborts the window.
//
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   sx, sy            timing generator counters; window opens at (0,VBLANK_LINE), deadline at (0,DEADLINE_LINE)
//   job_mask          jobs to run, sampled when the window opens
//   job_done          per-job completion strobes (only the running job's bit is looked at)
//   clr_status        clears the sticky overrun and job_timeout flags
//   job_start         one-hot single-cycle start pulse
//   busy              window in progress
//   frame_tick        pulse at window open; frame_done pulse when every job finished in time
//   overrun           sticky, deadline (or a re-open) hit with jobs outstanding
//   overrun_count     saturating overrun counter, cleared only by reset
//   job_timeout       sticky per-job timeout flags
//   frame_count       windows opened since reset, wraps
module vblank_job_scheduler #(
  parameter int N_JOBS        = 4,
  parameter int VBLANK_LINE   = 480,
  parameter int DEADLINE_LINE = 520,
  parameter int TIMEOUT       = 4096,
  parameter int FCW           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic [N_JOBS-1:0] job_mask,
  input  logic [N_JOBS-1:0] job_done,
  input  logic              clr_status,
  output logic [N_JOBS-1:0] job_start,
  output logic              busy,
  output logic              frame_tick,
  output logic              frame_done,
  output logic              overrun,
  output logic [7:0]        overrun_count,
  output logic [N_JOBS-1:0] job_timeout,
  output logic [FCW-1:0]    frame_count
);

  localparam int IW = (N_JOBS > 1) ? $clog2(N_JOBS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [9:0]    VB_LINE = 10'(VBLANK_LINE);
  localparam logic [9:0]    DL_LINE = 10'(DEADLINE_LINE);
  // Counter value seen in the last cycle a job may still report done.
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t            state, state_nxt;
  logic [N_JOBS-1:0] pending, pending_nxt;
  logic [IW-1:0]     cur, cur_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic [N_JOBS-1:0] job_start_nxt;
  logic              frame_tick_nxt, frame_done_nxt, overrun_nxt;
  logic [7:0]        overrun_count_nxt;
  logic [N_JOBS-1:0] job_timeout_nxt;
  logic [FCW-1:0]    frame_count_nxt;

  logic              open_evt, dl_evt, abort, ovr_set;
  logic [N_JOBS-1:0] to_set;
  logic [IW-1:0]     pick;
  logic [N_JOBS-1:0] pick_oh;

  assign open_evt = (sy == VB_LINE) && (sx == 10'd0);
  assign dl_evt   = (sy == DL_LINE) && (sx == 10'd0);
  assign busy     = (state != IDLE);

  // Lowest set bit of pending; scanning downwards lets the lowest index win.
  always_comb begin
    pick    = '0;
    pick_oh = '0;
    for (int i = N_JOBS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick    = IW'(i);
        pick_oh = N_JOBS'(1) << i;
      end
    end
  end

  // A re-open outside IDLE means the window never closed: treat it like a missed deadline.
  assign abort = (((state == ISSUE) || (state == WAIT)) && (open_evt || dl_evt)) ||
                 ((state == FINISH) && open_evt);

  always_comb begin
    state_nxt       = state;
    pending_nxt     = pending;
    cur_nxt         = cur;
    tcnt_nxt        = tcnt;
    job_start_nxt   = '0;
    frame_tick_nxt  = 1'b0;
    frame_done_nxt  = 1'b0;
    frame_count_nxt = frame_count;
    ovr_set         = 1'b0;
    to_set          = '0;

    if (abort) begin
      ovr_set     = 1'b1;
      pending_nxt = '0;
      state_nxt   = IDLE;
    end else begin
      case (state)
        IDLE: ;
        ISSUE: begin
          if (pending == '0) begin
            state_nxt = FINISH;
          end else begin
            // The start pulse is registered, so it lines up with the first WAIT cycle.
            pending_nxt   = pending & ~pick_oh;
            job_start_nxt = pick_oh;
            cur_nxt       = pick;
            tcnt_nxt      = '0;
            state_nxt     = WAIT;
          end
        end
        WAIT: begin
          if (job_done[cur]) begin
            state_nxt = ISSUE;
          end else if (tcnt == T_LAST) begin
            to_set[cur] = 1'b1;
            state_nxt   = ISSUE;
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
        FINISH: begin
          frame_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Every open_evt either opens from IDLE or has just aborted the old window.
    if (open_evt) begin
      pending_nxt     = job_mask;
      frame_tick_nxt  = 1'b1;
      frame_count_nxt = frame_count + FCW'(1);
      state_nxt       = ISSUE;
    end

    overrun_nxt       = ovr_set | (overrun & ~clr_status);
    overrun_count_nxt = (ovr_set && (overrun_count != 8'hFF)) ? overrun_count + 8'd1 : overrun_count;
    job_timeout_nxt   = (job_timeout & ~{N_JOBS{clr_status}}) | to_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pending       <= '0;
      cur           <= '0;
      tcnt          <= '0;
      job_start     <= '0;
      frame_tick    <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= 8'd0;
      job_timeout   <= '0;
      frame_count   <= '0;
    end else begin
      state         <= state_nxt;
      pending       <= pending_nxt;
      cur           <= cur_nxt;
      tcnt          <= tcnt_nxt;
      job_start     <= job_start_nxt;
      frame_tick    <= frame_tick_nxt;
      frame_done    <= frame_done_nxt;
      overrun       <= overrun_nxt;
      overrun_count <= overrun_count_nxt;
      job_timeout   <= job_timeout_nxt;
      frame_count   <= frame_count_nxt;
    end
  end

endmodule

// File: tb/tb_vblank_job_scheduler.sv
// tb_vblank_job_scheduler: directed stimulus with an event scoreboard for the vblank job scheduler.
// Latency: expected pulses carry the cycle they must appear in; status outputs are checked at fixed cycles.
// Backpressure: none; the bench drives job_done strobes itself.
module tb_vblank_job_scheduler;

  localparam int NJ = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    sx, sy;
  logic [NJ-1:0] job_mask, job_done;
  logic          clr_status;
  logic [NJ-1:0] job_start;
  logic          busy, frame_tick, frame_done, overrun;
  logic [7:0]    overrun_count;
  logic [NJ-1:0] job_timeout;
  logic [15:0]   frame_count;

  vblank_job_scheduler #(
    .N_JOBS(NJ), .VBLANK_LINE(480), .DEADLINE_LINE(520), .TIMEOUT(TO), .FCW(16)
  ) dut (
    .clk(clk), .reset(reset), .sx(sx), .sy(sy), .job_mask(job_mask), .job_done(job_done),
    .clr_status(clr_status), .job_start(job_start), .busy(busy), .frame_tick(frame_tick),
    .frame_done(frame_done), .overrun(overrun), .overrun_count(overrun_count),
    .job_timeout(job_timeout), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 frame_tick, 1 job_start (val = one-hot), 2 frame_done
  typedef struct {int cyc; int kind; int val;} ev_t;
  ev_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic expect_ev(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic see(input int k, input int v);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: kind %0d val %0d at cycle %0d, required none", k, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.kind != k || e.val != v) begin
        n_err++;
        $display("FAIL event: got kind %0d val %0d at cycle %0d, required kind %0d val %0d at cycle %0d",
                 k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: samples pulses mid-cycle and retires them against the scoreboard.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_event: kind %0d val %0d not seen, required at cycle %0d", q[0].kind, q[0].val, q[0].cyc);
      void'(q.pop_front());
    end
    if (frame_tick)  see(0, 1);
    if (|job_start)  see(1, int'(job_start));
    if (frame_done)  see(2, 1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  // Opens a window in the current cycle; returns that cycle (T).
  task automatic open_win(input logic [NJ-1:0] m, output int t);
    job_mask = m; sy = 10'd480; sx = 10'd0;
    t = cyc;
    expect_ev(t + 1, 0, 1);
    step(1);
    sy = 10'd0; sx = 10'd1;
  endtask

  // Expects job oh to start at s, returns done 5 cycles later; next start is 2 cycles after done.
  task automatic serve(input int s, input logic [NJ-1:0] oh, output int next_s);
    expect_ev(s, 1, int'(oh));
    wait_until(s + 5);
    job_done = oh;
    step(1);
    job_done = '0;
    next_s = s + 7;
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: bench still running at cycle %0d, required to end earlier", cyc);
    finish_run();
  end

  initial begin
    int t, s, n, c0;
    reset = 1'b1; sx = 10'd1; sy = 10'd0; job_mask = '0; job_done = '0; clr_status = 1'b0;
    step(3);
    check("rst_job_start", int'(job_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_tick", int'(frame_tick), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_overrun_count", int'(overrun_count), 0);
    check("rst_job_timeout", int'(job_timeout), 0);
    check("rst_frame_count", int'(frame_count), 0);
    reset = 1'b0;
    step(2);

    // Normal window: jobs 0,1,3
    open_win(4'b1011, t);
    check("normal_busy_open", int'(busy), 1);
    s = t + 2;
    serve(s, 4'b0001, s);
    serve(s, 4'b0010, s);
    serve(s, 4'b1000, s);
    expect_ev(s + 1, 2, 1);
    wait_until(s + 3);
    check("normal_frame_count", int'(frame_count), 1);
    check("normal_overrun", int'(overrun), 0);
    check("normal_busy_end", int'(busy), 0);

    // Empty mask: tick, then frame_done two cycles later, no starts
    open_win(4'b0000, t);
    expect_ev(t + 3, 2, 1);
    wait_until(t + 5);
    check("empty_frame_count", int'(frame_count), 2);

    // Timeout on job 1, job 3 still runs
    open_win(4'b1010, t);
    s = t + 2;
    expect_ev(s, 1, 2);
    wait_until(s + 15);
    check("timeout_before", int'(job_timeout), 0);
    step(1);
    check("timeout_set", int'(job_timeout), 2);
    serve(s + 17, 4'b1000, n);
    expect_ev(n + 1, 2, 1);
    wait_until(n + 3);
    check("timeout_sticky", int'(job_timeout), 2);
    check("timeout_no_overrun", int'(overrun), 0);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    check("timeout_cleared", int'(job_timeout), 0);

    // Deadline overrun with a done in the same cycle
    open_win(4'b0001, t);
    s = t + 2;
    expect_ev(s, 1, 1);
    wait_until(s + 3);
    sy = 10'd520; sx = 10'd0; job_done = 4'b0001;
    step(1);
    sy = 10'd0; sx = 10'd1; job_done = '0;
    check("dl_overrun", int'(overrun), 1);
    check("dl_overrun_count", int'(overrun_count), 1);
    check("dl_busy", int'(busy), 0);
    step(1);
    job_done = 4'b0001;
    step(1);
    job_done = '0;
    step(3);
    check("dl_late_busy", int'(busy), 0);
    check("dl_late_count", int'(overrun_count), 1);
    check("dl_frame_count", int'(frame_count), 4);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    check("dl_clr_overrun", int'(overrun), 0);
    check("dl_clr_keeps_count", int'(overrun_count), 1);

    // Reset while job 2 runs
    open_win(4'b0111, t);
    s = t + 2;
    serve(s, 4'b0001, s);
    serve(s, 4'b0010, s);
    expect_ev(s, 1, 4);
    wait_until(s + 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame_count", int'(frame_count), 0);
    check("midrst_overrun_count", int'(overrun_count), 0);
    check("midrst_job_start", int'(job_start), 0);
    step(2);
    open_win(4'b0001, t);
    check("midrst_reopen_count", int'(frame_count), 1);
    serve(t + 2, 4'b0001, n);
    expect_ev(n + 1, 2, 1);
    wait_until(n + 3);

    // Saturation: holding the open line re-opens every cycle, each one an overrun
    job_mask = '0; sy = 10'd480; sx = 10'd0;
    c0 = cyc;
    for (int i = 0; i < 258; i++) expect_ev(c0 + 1 + i, 0, 1);
    expect_ev(c0 + 260, 2, 1);
    step(255);
    check("sat_below", int'(overrun_count), 254);
    step(3);
    sy = 10'd0; sx = 10'd1;
    check("sat_count", int'(overrun_count), 255);
    wait_until(c0 + 262);
    check("sat_frame_count", int'(frame_count), 259);
    check("sat_busy", int'(busy), 0);
    check("sat_overrun", int'(overrun), 1);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    check("sat_clr_overrun", int'(overrun), 0);
    check("sat_clr_keeps_count", int'(overrun_count), 255);

    // Clear coincident with a new overrun: set wins
    open_win(4'b0001, t);
    s = t + 2;
    expect_ev(s, 1, 1);
    wait_until(s + 1);
    sy = 10'd520; sx = 10'd0; clr_status = 1'b1;
    step(1);
    sy = 10'd0; sx = 10'd1; clr_status = 1'b0;
    check("race_overrun", int'(overrun), 1);
    check("race_count", int'(overrun_count), 255);
    check("race_busy", int'(busy), 0);
    check("race_frame_count", int'(frame_count), 260);

    step(5);
    check("scoreboard_empty", q.size(), 0);
    finish_run();
  end

endmodule
